// File: rtl/dram_ctrl_pkg.sv
// rtl/dram_ctrl_pkg.sv - shared types, field geometry and chip-select decode for dram_ctrl
package dram_ctrl_pkg;

    localparam int BANK_W    = 5;
    localparam int ROW_W     = 5;
    localparam int COL_W     = 5;
    localparam int NUM_CHIPS = 32;

    // Byte address layout: {bank, row, col}
    localparam int COL_LSB  = 0;
    localparam int ROW_LSB  = COL_LSB + COL_W;
    localparam int BANK_LSB = ROW_LSB + ROW_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ROW,
        ST_COL,
        ST_PRE,
        ST_REF_CAS,
        ST_REF_RAS,
        ST_REF_PRE
    } state_t;

    // Active-low one-hot select for the addressed chip
    function automatic logic [NUM_CHIPS-1:0] chip_sel_n(input logic [BANK_W-1:0] bank);
        logic [NUM_CHIPS-1:0] onehot;
        onehot       = '0;
        onehot[bank] = 1'b1;
        return ~onehot;
    endfunction

endpackage

// File: rtl/dram_refresh_timer.sv
// rtl/dram_refresh_timer.sv - free-running refresh interval counter with pending and overrun flags
module dram_refresh_timer #(
    parameter int REFRESH_INTERVAL = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic refresh_ack,
    output logic pending,
    output logic overrun
);

    localparam int            CW     = $clog2(REFRESH_INTERVAL);
    localparam logic [CW-1:0] RELOAD = CW'(REFRESH_INTERVAL - 1);

    logic [CW-1:0] count;

    // Count down every cycle; on expiry raise one pending refresh, flag overrun if one was already waiting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= RELOAD;
            pending <= 1'b0;
            overrun <= 1'b0;
        end else if (count == '0) begin
            count   <= RELOAD;
            pending <= 1'b1;
            if (pending && !refresh_ack) begin
                overrun <= 1'b1;
            end
        end else begin
            count <= count - 1'b1;
            if (refresh_ack) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dram_ctrl.sv
// rtl/dram_ctrl.sv - access and CBR refresh sequencer for the 32-chip multiplexed-address DRAM array
module dram_ctrl
    import dram_ctrl_pkg::*;
#(
    parameter int ADDR_W           = 15,
    parameter int DATA_W           = 8,
    parameter int T_RCD            = 2,
    parameter int T_CAS            = 2,
    parameter int T_RP             = 2,
    parameter int REFRESH_INTERVAL = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [DATA_W-1:0]    req_wdata,
    output logic                 rsp_valid,
    output logic [DATA_W-1:0]    rsp_rdata,
    output logic [COL_W-1:0]     dram_addr,
    output logic                 dram_ras_n,
    output logic                 dram_cas_n,
    output logic                 dram_we_n,
    output logic [NUM_CHIPS-1:0] dram_cs_n,
    output logic [DATA_W-1:0]    dram_dq_out,
    output logic                 dram_dq_oe,
    input  logic [DATA_W-1:0]    dram_dq_in,
    output logic                 refresh_busy,
    output logic                 refresh_overrun
);

    // Longest multi-cycle state decides the dwell counter width
    localparam int SPAN  = (T_RCD + T_CAS > T_RP) ? (T_RCD + T_CAS) : T_RP;
    localparam int CNT_W = $clog2(SPAN + 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [ADDR_W-1:0]  addr_q;
    logic               we_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               pending;
    logic               refresh_ack;

    dram_refresh_timer #(
        .REFRESH_INTERVAL (REFRESH_INTERVAL)
    ) u_refresh_timer (
        .clk         (clk),
        .rst         (rst),
        .refresh_ack (refresh_ack),
        .pending     (pending),
        .overrun     (refresh_overrun)
    );

    // The pending refresh is consumed while the CBR sequence is opening
    assign refresh_ack = (state == ST_REF_CAS);

    // Only an idle controller with no refresh waiting takes a request; held low while in reset
    assign req_ready = !rst && (state == ST_IDLE) && !pending;

    // Sequencer: outputs are loaded on entry to each state so they stay constant for its dwell
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            dram_addr    <= '0;
            dram_ras_n   <= 1'b1;
            dram_cas_n   <= 1'b1;
            dram_we_n    <= 1'b1;
            dram_cs_n    <= '1;
            dram_dq_out  <= '0;
            dram_dq_oe   <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            refresh_busy <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pending) begin
                        state        <= ST_REF_CAS;
                        dram_cs_n    <= '0;
                        dram_cas_n   <= 1'b0;
                        refresh_busy <= 1'b1;
                    end else if (req_valid) begin
                        state      <= ST_ROW;
                        cnt        <= CNT_W'(T_RCD - 1);
                        addr_q     <= req_addr;
                        we_q       <= req_we;
                        wdata_q    <= req_wdata;
                        dram_addr  <= req_addr[ROW_LSB +: ROW_W];
                        dram_cs_n  <= chip_sel_n(req_addr[BANK_LSB +: BANK_W]);
                        dram_ras_n <= 1'b0;
                    end
                end
                ST_ROW: begin
                    if (cnt == '0) begin
                        state      <= ST_COL;
                        cnt        <= CNT_W'(T_CAS - 1);
                        dram_addr  <= addr_q[COL_LSB +: COL_W];
                        dram_cas_n <= 1'b0;
                        dram_we_n  <= !we_q;
                        dram_dq_oe <= we_q;
                        if (we_q) begin
                            dram_dq_out <= wdata_q;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_COL: begin
                    if (cnt == '0) begin
                        state      <= ST_PRE;
                        cnt        <= CNT_W'(T_RP - 1);
                        dram_ras_n <= 1'b1;
                        dram_cas_n <= 1'b1;
                        dram_we_n  <= 1'b1;
                        dram_cs_n  <= '1;
                        dram_dq_oe <= 1'b0;
                        rsp_valid  <= 1'b1;
                        if (!we_q) begin
                            rsp_rdata <= dram_dq_in;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_PRE: begin
                    if (cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_REF_CAS: begin
                    state      <= ST_REF_RAS;
                    cnt        <= CNT_W'(T_RCD + T_CAS - 1);
                    dram_ras_n <= 1'b0;
                end
                ST_REF_RAS: begin
                    if (cnt == '0) begin
                        state      <= ST_REF_PRE;
                        cnt        <= CNT_W'(T_RP - 1);
                        dram_ras_n <= 1'b1;
                        dram_cas_n <= 1'b1;
                        dram_cs_n  <= '1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_REF_PRE: begin
                    if (cnt == '0) begin
                        state        <= ST_IDLE;
                        refresh_busy <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dram_ctrl.sv
// tb/tb_dram_ctrl.sv - timeline-model and directed checks for dram_ctrl
module tb_dram_ctrl;

    localparam int T_RCD = 2;
    localparam int T_CAS = 2;
    localparam int T_RP  = 2;
    localparam int RI    = 16;
    localparam int LA    = T_RCD + T_CAS + T_RP;
    localparam int LR    = 1 + T_RCD + T_CAS + T_RP;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [14:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic [4:0]  dram_addr;
    logic        dram_ras_n;
    logic        dram_cas_n;
    logic        dram_we_n;
    logic [31:0] dram_cs_n;
    logic [7:0]  dram_dq_out;
    logic        dram_dq_oe;
    logic [7:0]  dram_dq_in;
    logic        refresh_busy;
    logic        refresh_overrun;

    int total = 0;
    int bad   = 0;
    int tcyc;

    dram_ctrl #(
        .ADDR_W           (15),
        .DATA_W           (8),
        .T_RCD            (T_RCD),
        .T_CAS            (T_CAS),
        .T_RP             (T_RP),
        .REFRESH_INTERVAL (RI)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_we          (req_we),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_rdata       (rsp_rdata),
        .dram_addr       (dram_addr),
        .dram_ras_n      (dram_ras_n),
        .dram_cas_n      (dram_cas_n),
        .dram_we_n       (dram_we_n),
        .dram_cs_n       (dram_cs_n),
        .dram_dq_out     (dram_dq_out),
        .dram_dq_oe      (dram_dq_oe),
        .dram_dq_in      (dram_dq_in),
        .refresh_busy    (refresh_busy),
        .refresh_overrun (refresh_overrun)
    );

    always #5 clk = ~clk;

    // Cycle index since reset release: cycle 0 is the first cycle after rst falls
    always @(posedge clk or posedge rst) begin
        if (rst) tcyc <= 0;
        else     tcyc <= tcyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, tcyc, got, exp);
        end
    endtask

    // ---------------- timeline model ----------------
    int          m_act;      // 0 idle, 1 access, 2 refresh
    int          m_start;
    logic        m_we;
    logic [14:0] m_addr;
    logic [7:0]  m_wdata;
    logic        m_pend;
    logic        m_ovr;
    logic [7:0]  m_rdata;
    logic [7:0]  m_sample;

    always @(negedge clk) begin
        if (rst) begin
            m_act = 0; m_start = 0; m_we = 0; m_addr = '0; m_wdata = '0;
            m_pend = 0; m_ovr = 0; m_rdata = '0; m_sample = '0;
        end else begin
            int          p;
            logic        e_ras, e_cas, e_we, e_oe, e_rv, ck_addr, clr, old_pend;
            logic [31:0] e_cs;
            logic [4:0]  e_addr;
            p = tcyc - m_start;
            e_ras = 1; e_cas = 1; e_we = 1; e_oe = 0; e_rv = 0; ck_addr = 0;
            e_cs = '1; e_addr = '0;
            if (m_act == 1) begin
                if (p < T_RCD) begin
                    e_ras = 0; e_cs = ~(32'd1 << m_addr[14:10]);
                    ck_addr = 1; e_addr = m_addr[9:5];
                end else if (p < T_RCD + T_CAS) begin
                    e_ras = 0; e_cas = 0; e_cs = ~(32'd1 << m_addr[14:10]);
                    e_we = !m_we; e_oe = m_we; ck_addr = 1; e_addr = m_addr[4:0];
                    if (p == T_RCD + T_CAS - 1) m_sample = dram_dq_in;
                end else if (p == T_RCD + T_CAS) begin
                    e_rv = 1;
                    if (!m_we) m_rdata = m_sample;
                end
            end else if (m_act == 2) begin
                if (p == 0) begin
                    e_cas = 0; e_cs = '0;
                end else if (p <= T_RCD + T_CAS) begin
                    e_ras = 0; e_cas = 0; e_cs = '0;
                end
            end
            chk("ras_n",     32'(dram_ras_n),      32'(e_ras));
            chk("cas_n",     32'(dram_cas_n),      32'(e_cas));
            chk("we_n",      32'(dram_we_n),       32'(e_we));
            chk("cs_n",      dram_cs_n,            e_cs);
            chk("dq_oe",     32'(dram_dq_oe),      32'(e_oe));
            chk("rsp_valid", 32'(rsp_valid),       32'(e_rv));
            chk("rsp_rdata", 32'(rsp_rdata),       32'(m_rdata));
            chk("busy",      32'(refresh_busy),    32'(m_act == 2));
            chk("req_ready", 32'(req_ready),       32'(m_act == 0 && !m_pend));
            chk("overrun",   32'(refresh_overrun), 32'(m_ovr));
            if (ck_addr) chk("dram_addr", 32'(dram_addr), 32'(e_addr));
            if (e_oe)    chk("dq_out", 32'(dram_dq_out), 32'(m_wdata));

            // advance the model to the next cycle
            old_pend = m_pend;
            clr = (m_act == 2 && p == 0);
            if (tcyc % RI == RI - 1) begin
                if (m_pend && !clr) m_ovr = 1;
                m_pend = 1;
            end else if (clr) begin
                m_pend = 0;
            end
            if (m_act != 0) begin
                if (p == ((m_act == 1) ? LA : LR) - 1) m_act = 0;
            end else if (old_pend) begin
                m_act = 2; m_start = tcyc + 1;
            end else if (req_valid) begin
                m_act = 1; m_start = tcyc + 1;
                m_we = req_we; m_addr = req_addr; m_wdata = req_wdata;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    // Land just after the rising edge that opens cycle c
    task automatic at_cycle(input int c);
        while (tcyc != c) begin
            if (tcyc > c) begin
                chk("cycle_sync", 32'(tcyc), 32'(c));
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic at_neg(input int c);
        at_cycle(c);
        @(negedge clk);
    endtask

    initial begin
        int busy_cnt, rdy_hi, hs, k, rspc;
        int hsv[4];
        rst = 1; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0;
        dram_dq_in = 8'h3C;

        @(negedge clk);
        chk("rst_ras_n",   32'(dram_ras_n), 32'd1);
        chk("rst_cas_n",   32'(dram_cas_n), 32'd1);
        chk("rst_we_n",    32'(dram_we_n), 32'd1);
        chk("rst_cs_n",    dram_cs_n, 32'hFFFF_FFFF);
        chk("rst_dq_oe",   32'(dram_dq_oe), 32'd0);
        chk("rst_addr",    32'(dram_addr), 32'd0);
        chk("rst_dq_out",  32'(dram_dq_out), 32'd0);
        chk("rst_ready",   32'(req_ready), 32'd0);
        chk("rst_rsp",     32'(rsp_valid), 32'd0);
        chk("rst_rdata",   32'(rsp_rdata), 32'd0);
        chk("rst_busy",    32'(refresh_busy), 32'd0);
        chk("rst_overrun", 32'(refresh_overrun), 32'd0);

        @(posedge clk); #1; rst = 0;

        // write 0xA5 to 0x5A3C, handshake in cycle 0
        req_valid = 1; req_we = 1; req_addr = 15'h5A3C; req_wdata = 8'hA5;
        @(negedge clk);
        chk("wr_ready", 32'(req_ready), 32'd1);
        at_cycle(1); req_valid = 0;
        @(negedge clk);
        chk("wr_row_addr", 32'(dram_addr), 32'h11);
        chk("wr_cs_n", dram_cs_n, 32'hFFBF_FFFF);
        chk("wr_row_ras", 32'(dram_ras_n), 32'd0);
        at_neg(3);
        chk("wr_col_addr", 32'(dram_addr), 32'h1C);
        chk("wr_col_we", 32'(dram_we_n), 32'd0);
        chk("wr_col_oe", 32'(dram_dq_oe), 32'd1);
        chk("wr_col_dq", 32'(dram_dq_out), 32'hA5);
        at_neg(5);
        chk("wr_rsp", 32'(rsp_valid), 32'd1);

        // read from 0x0001, handshake in cycle 7
        at_cycle(7); req_valid = 1; req_we = 0; req_addr = 15'h0001;
        @(negedge clk);
        chk("rd_ready", 32'(req_ready), 32'd1);
        at_cycle(8); req_valid = 0;
        @(negedge clk);
        chk("rd_cs_n", dram_cs_n, 32'hFFFF_FFFE);
        chk("rd_row_addr", 32'(dram_addr), 32'h00);
        at_neg(10);
        chk("rd_col_addr", 32'(dram_addr), 32'h01);
        chk("rd_col_we", 32'(dram_we_n), 32'd1);
        at_neg(12);
        chk("rd_rsp", 32'(rsp_valid), 32'd1);
        chk("rd_rdata", 32'(rsp_rdata), 32'h3C);

        // idle refresh: pending visible in cycle 16, CBR in 17..23
        busy_cnt = 0; rdy_hi = 0;
        for (int c = 14; c <= 26; c++) begin
            at_neg(c);
            if (refresh_busy) busy_cnt++;
            if (c >= 16 && c <= 23 && req_ready) rdy_hi++;
            if (c == 15) chk("ref_ready_before", 32'(req_ready), 32'd1);
            if (c == 17) begin
                chk("ref_cas_first", 32'(dram_cas_n), 32'd0);
                chk("ref_ras_late", 32'(dram_ras_n), 32'd1);
                chk("ref_cs_all", dram_cs_n, 32'd0);
            end
            if (c == 18) chk("ref_ras", 32'(dram_ras_n), 32'd0);
            if (c == 24) chk("ref_ready_after", 32'(req_ready), 32'd1);
        end
        chk("ref_busy_cycles", 32'(busy_cnt), 32'd7);
        chk("ref_ready_low", 32'(rdy_hi), 32'd0);

        // read whose COL spans the timer expiry at the end of cycle 31
        at_cycle(28); req_valid = 1; req_we = 0; req_addr = 15'h2421; dram_dq_in = 8'hC3;
        at_cycle(29); req_valid = 0;
        at_neg(33);
        chk("exp_rsp", 32'(rsp_valid), 32'd1);
        chk("exp_rdata", 32'(rsp_rdata), 32'hC3);
        at_neg(36);
        chk("exp_ref_busy", 32'(refresh_busy), 32'd1);
        chk("exp_ref_cas", 32'(dram_cas_n), 32'd0);
        at_cycle(37); req_valid = 1; req_we = 1; req_addr = 15'h7FFF; req_wdata = 8'h5A;
        hs = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_ready) begin
                hs = tcyc;
                break;
            end
        end
        chk("exp_wait_hs", 32'(hs), 32'd43);
        at_cycle(hs + 1); req_valid = 0;
        @(negedge clk);
        chk("top_cs_n", dram_cs_n, 32'h7FFF_FFFF);
        chk("top_row_addr", 32'(dram_addr), 32'h1F);

        // back-to-back with req_valid held from cycle 58
        at_cycle(58); req_valid = 1; req_we = 0; req_addr = 15'h0421; req_wdata = 8'h11;
        k = 0; rspc = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (rsp_valid) rspc++;
            if (tcyc >= 104) break;
            if (req_valid && req_ready) begin
                if (k < 4) hsv[k] = tcyc;
                k++;
                @(posedge clk); #1;
                if (k >= 4) begin
                    req_valid = 0;
                end else begin
                    req_we    = ~req_we;
                    req_addr  = req_addr + 15'h0423;
                    req_wdata = req_wdata + 8'h22;
                end
            end
        end
        chk("b2b_count", 32'(k), 32'd4);
        chk("b2b_hs0", 32'(hsv[0]), 32'd58);
        chk("b2b_hs1", 32'(hsv[1]), 32'd73);
        chk("b2b_hs2", 32'(hsv[2]), 32'd88);
        chk("b2b_hs3", 32'(hsv[3]), 32'd95);
        chk("b2b_rsp", 32'(rspc), 32'd4);

        // reset asserted during COL of a write
        at_cycle(110); req_valid = 1; req_we = 1; req_addr = 15'h1234; req_wdata = 8'h77;
        at_cycle(111); req_valid = 0;
        at_cycle(113);
        chk("pre_rst_cas", 32'(dram_cas_n), 32'd0);
        #1 rst = 1;
        #1;
        chk("mid_rst_ras", 32'(dram_ras_n), 32'd1);
        chk("mid_rst_cas", 32'(dram_cas_n), 32'd1);
        chk("mid_rst_we", 32'(dram_we_n), 32'd1);
        chk("mid_rst_cs", dram_cs_n, 32'hFFFF_FFFF);
        chk("mid_rst_oe", 32'(dram_dq_oe), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        @(posedge clk); #1; rst = 0;
        rspc = 0;
        for (int c = 0; c <= 16; c++) begin
            at_neg(c);
            if (rsp_valid) rspc++;
            if (c == 0)  chk("rel_ready", 32'(req_ready), 32'd1);
            if (c == 15) chk("rel_ready_15", 32'(req_ready), 32'd1);
            if (c == 16) chk("rel_pending_16", 32'(req_ready), 32'd0);
        end
        chk("rel_no_rsp", 32'(rspc), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog cycle=%0d", tcyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dram_ctrl.md
Name: dram_ctrl

Overview:
- Sequencing controller for the 32-chip, 32K x 8 multiplexed-address DRAM array.
- Accepts single-byte read/write requests over a valid/ready interface.
- Decodes the 32 per-chip selects from the bank address and drives multiplexed row/column addresses with RAS/CAS/WE strobes.
- Inserts CAS-before-RAS refresh cycles on a fixed interval; refresh has priority over new requests.

Parameters:
- ADDR_W, 15, host byte address width; bits [14:10] select the chip, bits [9:5] are the row, bits [4:0] are the column.
- DATA_W, 8, data width.
- T_RCD, 2, cycles RAS is asserted before CAS (min 1).
- T_CAS, 2, cycles CAS is asserted (min 1).
- T_RP, 2, precharge cycles with all strobes high (min 1).
- REFRESH_INTERVAL, 256, cycles between refresh requests (min 16).

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  host request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  15  byte address.
- req_wdata  in  8  write data.
- rsp_valid  out  1  one-cycle pulse on completion of a read or write.
- rsp_rdata  out  8  read data; valid while rsp_valid=1 and held until the next read completes.
- dram_addr  out  5  multiplexed row/column address.
- dram_ras_n  out  1  row strobe, shared by all chips, active low.
- dram_cas_n  out  1  column strobe, shared by all chips, active low.
- dram_we_n  out  1  write enable, active low.
- dram_cs_n  out  32  per-chip select, active low.
- dram_dq_out  out  8  write data to the array.
- dram_dq_oe  out  1  drive enable for dram_dq_out.
- dram_dq_in  in  8  read data from the array.
- refresh_busy  out  1  high while a refresh sequence is in progress.
- refresh_overrun  out  1  sticky; set when the interval expires while a refresh is still pending.

Behaviour:
- Reset (asynchronous, immediate, including mid-access):
  - ras_n = cas_n = we_n = 1; cs_n = all 1s; dq_oe = 0; dram_addr = 0; dq_out = 0.
  - req_ready = 0 during reset, 1 on the first cycle after release.
  - rsp_valid = 0; rsp_rdata = 0; refresh_busy = 0; refresh_overrun = 0.
  - State = IDLE; refresh counter = REFRESH_INTERVAL-1; pending = 0.
  - An interrupted access produces no rsp_valid.
- States: IDLE, ROW, COL, PRE, REF_CAS, REF_RAS, REF_PRE.
- IDLE:
  - req_ready = !pending.
  - If pending, go to REF_CAS; requests are not accepted that cycle.
  - Otherwise, on req_valid & req_ready, latch addr, we and wdata, then go to ROW.
- ROW, T_RCD cycles:
  - dram_addr = row; cs_n[addr[14:10]] = 0, all other cs_n = 1; ras_n = 0.
- COL, T_CAS cycles:
  - dram_addr = col; ras_n = 0; cas_n = 0; we_n = !we.
  - Writes: dq_oe = 1 and dq_out = wdata for the whole state.
  - Reads: dram_dq_in is sampled on the last COL cycle.
- PRE, T_RP cycles:
  - All strobes high; cs_n all 1s; dq_oe = 0.
  - rsp_valid pulses on the first PRE cycle; for reads, rsp_rdata is updated on the same cycle.
  - Then go to IDLE.
- Latency with defaults, handshake in cycle N:
  - RAS low in N+1..N+2; CAS low in N+3..N+4.
  - rsp_valid in N+5.
  - req_ready high again in N+7.
- Refresh timer:
  - Free-running down-counter, decremented every cycle in every state.
  - At 0: reload to REFRESH_INTERVAL-1 and set pending.
  - If pending is already set at expiry, set refresh_overrun instead; only one pending refresh is held.
- Refresh sequence (CBR):
  - REF_CAS, 1 cycle: cs_n all 0; cas_n = 0; ras_n = 1; pending cleared.
  - REF_RAS, T_RCD+T_CAS cycles: cas_n = 0 and ras_n = 0.
  - REF_PRE, T_RP cycles: all strobes high, cs_n all 1s.
  - refresh_busy = 1 from REF_CAS through the last REF_PRE cycle.
  - we_n = 1 and dq_oe = 0 throughout.
- Precedence and simultaneous events:
  - An in-flight access is never aborted by refresh; refresh starts from IDLE after PRE.
  - If the timer expires in the same cycle as a handshake, the access proceeds and the refresh follows it.
- req_ready is low in every state except IDLE-with-no-pending; host inputs are ignored while it is low.
- No back-to-back overlap: one access completes its full sequence, PRE included, before the next handshake.

Decomposition:
- Package dram_ctrl_pkg holds:
  - State enum.
  - Field widths and slices: BANK_W = 5, ROW_W = 5, COL_W = 5, NUM_CHIPS = 32.
  - Helper constants for bank/row/col bit ranges.
- One sub-module, dram_refresh_timer: the down-counter, pending flag and overrun flag, with a refresh_ack input that clears pending.
- The FSM and strobe generation stay in dram_ctrl.

Test Plan:
- Single write to addr 0x5A3C, data 0xA5:
  - cs_n[22] = 0 (all others 1) during ROW/COL.
  - dram_addr = 0x11 during ROW, 0x1C during COL; we_n = 0 and dq_oe = 1 during COL.
  - rsp_valid at N+5.
- Single read from addr 0x0001 with dram_dq_in = 0x3C:
  - cs_n[0] = 0; row = 0, col = 1; we_n = 1 throughout.
  - rsp_valid at N+5 with rsp_rdata = 0x3C.
- REFRESH_INTERVAL = 16, no traffic:
  - Pending set at cycle 16, then REF_CAS.
  - cas_n falls one cycle before ras_n; all cs_n = 0; refresh_busy high for 1+4+2 = 7 cycles; req_ready low throughout.
- Timer expiry during a read's COL state:
  - Read completes normally with correct data.
  - Refresh begins immediately after PRE; the next host request waits until refresh ends.
- Back-to-back requests with req_valid held high:
  - Handshakes are exactly 7 cycles apart with defaults.
  - Every request gets exactly one rsp_valid.
- rst asserted during COL of a write:
  - All strobes go high and cs_n all 1s in the same cycle as rst; no rsp_valid is produced.
  - req_ready = 1 on the first cycle after release, and the refresh counter restarts at REFRESH_INTERVAL-1.
